// File: rtl/xor5_sched_pkg.sv
// Shared types and constants for the xor5 parity scheduler.
package xor5_sched_pkg;

    localparam int unsigned CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/xor5_unit.sv
// Shared 5-input XOR reduction datapath.
module xor5_unit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    input  logic i_e,
    output logic o_y
);

    assign o_y = i_a ^ i_b ^ i_c ^ i_d ^ i_e;

endmodule

// File: rtl/xor5_parity_scheduler.sv
// Round-robin scheduler that folds one accepted word per transaction through
// the shared xor5 unit, 4 bits per cycle, and returns its parity and requester ID.
module xor5_parity_scheduler
    import xor5_sched_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_parity,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     busy
);

    localparam int unsigned K   = WIDTH / CHUNK;
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = (K > 1) ? $clog2(K) : 1;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sh, w_sh_nxt;
    logic             r_acc, w_acc_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [IDW-1:0]   r_last, w_last_nxt;
    logic [IDW-1:0]   r_id, w_id_nxt;
    logic             r_vld, w_vld_nxt;
    logic             r_par, w_par_nxt;
    logic             r_busy, w_busy_nxt;

    logic             w_any;
    logic [IDW-1:0]   w_grant;
    logic [WIDTH-1:0] w_word;
    logic             w_fold;

    // First valid requester searching upward from the one after the last grant.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick;
        logic           found;
        int unsigned    idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last) + k) % NREQ;
            if (!found && v[IDW'(idx)]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_any   = |req_valid;
    assign w_grant = rr_pick(req_valid, r_last);

    always_comb begin
        w_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_grant == IDW'(i)) w_word = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Running parity is the fifth input alongside the low nibble of the shifter.
    xor5_unit u_xor5 (
        .i_a (r_acc),
        .i_b (r_sh[0]),
        .i_c (r_sh[1]),
        .i_d (r_sh[2]),
        .i_e (r_sh[3]),
        .o_y (w_fold)
    );

    // Accept strobe depends only on state, req_valid and last grant.
    always_comb begin
        req_ready = '0;
        if (r_state == IDLE && w_any) req_ready[w_grant] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_id_nxt    = r_id;
        w_vld_nxt   = r_vld;
        w_par_nxt   = r_par;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_sh_nxt    = w_word;
                    w_acc_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_id_nxt    = w_grant;
                    w_last_nxt  = w_grant;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_acc_nxt = w_fold;
                w_sh_nxt  = r_sh >> CHUNK;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(K - 1)) begin
                    w_par_nxt   = w_fold;
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= '0;
            r_acc  <= 1'b0;
            r_cnt  <= '0;
            r_last <= IDW'(NREQ - 1);
            r_id   <= '0;
            r_vld  <= 1'b0;
            r_par  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_sh   <= w_sh_nxt;
            r_acc  <= w_acc_nxt;
            r_cnt  <= w_cnt_nxt;
            r_last <= w_last_nxt;
            r_id   <= w_id_nxt;
            r_vld  <= w_vld_nxt;
            r_par  <= w_par_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    assign rsp_valid  = r_vld;
    assign rsp_parity = r_par;
    assign rsp_id     = r_id;
    assign busy       = r_busy;

endmodule

// File: tb/tb_xor5_parity_scheduler.sv
// Directed and random bench for xor5_parity_scheduler with a parity/ID scoreboard.
module tb_xor5_parity_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_parity;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    always #5 clk = ~clk;

    xor5_parity_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_parity (rsp_parity),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    logic [IDW:0] exp_q[$];
    int           acc_q[$];
    int           grant_log[$];
    int           rdy_cnt[NREQ];
    int           last_acc;
    bit           rsp_seen = 1'b0;
    bit           rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe the settled pre-edge state, update the scoreboard, advance.
    task automatic tick();
        logic [IDW:0] e;
        #1;
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
        last_acc = -1;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            rsp_seen = 1'b0;
        end else begin
            if (busy) chk("ready_while_busy", 32'(req_ready), 32'd0);
            if (req_ready != '0) chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
            for (int i = 0; i < NREQ; i++) begin
                rdy_cnt[i] += int'(req_ready[i]);
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({^req_data[i*WIDTH +: WIDTH], IDW'(i)});
                    acc_q.push_back(cyc);
                    grant_log.push_back(i);
                    last_acc = i;
                end
            end
            if (rsp_valid && !rsp_seen) begin
                rsp_seen = 1'b1;
                chk("rsp_expected", 32'(acc_q.size()), 32'd1);
                if (acc_q.size() > 0) chk("latency", 32'(cyc - acc_q[0]), 32'd5);
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    chk("rsp_parity", 32'(rsp_parity), 32'(e[IDW]));
                    chk("rsp_id", 32'(rsp_id), 32'(e[IDW-1:0]));
                end
                rsp_seen = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int id, input logic [WIDTH-1:0] d);
        bit got = 1'b0;
        req_data[id*WIDTH +: WIDTH] = d;
        req_valid[id] = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            tick();
            got = (last_acc == id);
        end
        req_valid[id] = 1'b0;
        chk("send_accept", 32'(got), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() > 0; n++) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_parity", 32'(rsp_parity), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        // Single word, then two words from the same requester.
        send(2, 16'h0001); drain();
        send(1, 16'hFFFF); drain();
        send(1, 16'h8421); drain();

        // Requesters 0 and 3 contend straight out of reset.
        rst = 1'b1; tick(); rst = 1'b0;
        grant_log.delete();
        req_data[0 +: WIDTH] = 16'h1234;
        req_data[3*WIDTH +: WIDTH] = 16'hBEEF;
        req_valid = 4'b1001;
        for (int n = 0; n < 60 && grant_log.size() < 2; n++) begin
            tick();
            if (last_acc >= 0) req_valid[last_acc] = 1'b0;
        end
        chk("pair_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            chk("pair_first", 32'(grant_log[0]), 32'd0);
            chk("pair_second", 32'(grant_log[1]), 32'd3);
        end
        drain();

        // All four continuously valid: one full round then wrap to 0.
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            rdy_cnt[i] = 0;
            req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        req_valid = 4'hF;
        for (int n = 0; n < 100 && grant_log.size() < 4; n++) begin
            tick();
            if (last_acc >= 0) req_data[last_acc*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        for (int i = 0; i < NREQ; i++) chk("round_ready_pulses", 32'(rdy_cnt[i]), 32'd1);
        for (int n = 0; n < 100 && grant_log.size() < 5; n++) tick();
        req_valid = '0;
        chk("round_grants", 32'(grant_log.size()), 32'd5);
        if (grant_log.size() >= 5)
            for (int i = 0; i < 5; i++) chk("round_order", 32'(grant_log[i]), 32'(i % NREQ));
        drain();

        // Consumer stalls three cycles in RESP.
        rsp_ready = 1'b0;
        send(3, 16'hA5C3);
        for (int n = 0; n < 20 && !rsp_valid; n++) tick();
        chk("stall_valid_seen", 32'(rsp_valid), 32'd1);
        req_valid = 4'hF;
        repeat (3) begin
            #1;
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_parity", 32'(rsp_parity), 32'd0);
            chk("stall_id", 32'(rsp_id), 32'd3);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("hs_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = '0;
        #1;
        chk("hs_valid_low", 32'(rsp_valid), 32'd0);
        chk("hs_busy_low", 32'(busy), 32'd0);
        drain();

        // Reset in the second RUN cycle drops the word.
        send(2, 16'h0007);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        repeat (10) tick();
        grant_log.delete();
        req_data[1*WIDTH +: WIDTH] = 16'h00F1;
        req_data[2*WIDTH +: WIDTH] = 16'h0F02;
        req_valid = 4'b0110;
        for (int n = 0; n < 20 && grant_log.size() < 1; n++) tick();
        req_valid = '0;
        chk("midrst_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);
        drain();

        // Random sweep with random consumer backpressure.
        rand_rdy = 1'b1;
        repeat (1000) send(int'($urandom_range(0, NREQ - 1)), WIDTH'($urandom));
        rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
